// File: rtl/prog_loader_if.sv
// Serial program stream and instruction-memory write port of one tile loader.
// The loader uses the slave modport. The upstream driver and memory side use master.
interface prog_loader_if #(
  parameter int ADDR_W = 7
);
  logic              program_mode;
  logic              ser_in;
  logic              ser_valid;
  logic              ser_out;
  logic              ins_we;
  logic [ADDR_W-1:0] ins_addr;
  logic [63:0]       ins_wdata;
  logic              busy;
  logic              load_done;
  logic              load_err;

  modport slave (
    input  program_mode, ser_in, ser_valid,
    output ser_out, ins_we, ins_addr, ins_wdata, busy, load_done, load_err
  );

  modport master (
    output program_mode, ser_in, ser_valid,
    input  ser_out, ins_we, ins_addr, ins_wdata, busy, load_done, load_err
  );
endinterface

// File: rtl/prog_loader.sv
// Per-tile instruction loader.
// It hunts a serial stream for SYNC/ID/N frames, then deserializes N 64-bit
// words LSB first and writes each word to instruction memory.
// The frame ends with an XOR checksum byte.
// Frames for other tiles are skipped by bit count.
// The raw stream is forwarded one cycle later to the next tile in the chain.
module prog_loader #(
  parameter int         TILE_ID = 0,
  parameter int         DEPTH   = 128,
  parameter int         ADDR_W  = 7,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    HUNT, HDR_ID, HDR_CNT, PAYLOAD, CHECK, SKIP, DONE, ERR
  } state_t;

  state_t state, state_d;

  logic [7:0]        sr8, sr8_nx, id_q, n_words, widx, chk_acc;
  logic [63:0]       sr64, sr64_nx;
  logic [5:0]        bcnt;
  logic [14:0]       skip_rem;
  logic              consume, byte_done, word_done;
  logic              set_done, set_err, clr_flags, ld_payload, ld_skip;
  logic              ser_out_q, we_q, done_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;

  function automatic logic [7:0] byte_xor(input logic [63:0] w);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < 8; i++) x ^= w[8*i +: 8];
    return x;
  endfunction

  assign consume   = bus.program_mode & bus.ser_valid;
  assign sr8_nx    = {bus.ser_in, sr8[7:1]};
  assign sr64_nx   = {bus.ser_in, sr64[63:1]};
  assign byte_done = consume && (bcnt == 6'd7);
  assign word_done = consume && (bcnt == 6'd63);

  assign bus.ser_out   = ser_out_q;
  assign bus.ins_we    = we_q;
  assign bus.ins_addr  = addr_q;
  assign bus.ins_wdata = wdata_q;
  assign bus.load_done = done_q;
  assign bus.load_err  = err_q;
  assign bus.busy      = !(state inside {HUNT, DONE, ERR});

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HUNT;
    else      state <= state_d;
  end

  // Frame sequencing. Losing program_mode mid-header abandons the frame silently.
  // Losing it after words may have been written is flagged as an error.
  always_comb begin
    state_d    = state;
    set_done   = 1'b0;
    set_err    = 1'b0;
    clr_flags  = 1'b0;
    ld_payload = 1'b0;
    ld_skip    = 1'b0;
    case (state)
      HUNT: begin
        if (consume && sr8_nx == SYNC) begin
          state_d   = HDR_ID;
          clr_flags = 1'b1;
        end
      end
      HDR_ID: begin
        if (!bus.program_mode) state_d = HUNT;
        else if (byte_done)    state_d = HDR_CNT;
      end
      HDR_CNT: begin
        if (!bus.program_mode) state_d = HUNT;
        else if (byte_done) begin
          if (id_q == 8'(TILE_ID)) begin
            if (sr8_nx != 8'd0 && int'(sr8_nx) <= DEPTH) begin
              state_d    = PAYLOAD;
              ld_payload = 1'b1;
            end else begin
              state_d = ERR;
              set_err = 1'b1;
            end
          end else begin
            state_d = SKIP;
            ld_skip = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (!bus.program_mode) begin
          state_d = ERR;
          set_err = 1'b1;
        end else if (word_done && widx == n_words - 8'd1) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!bus.program_mode) begin
          state_d = ERR;
          set_err = 1'b1;
        end else if (byte_done) begin
          if (sr8_nx == chk_acc) begin
            state_d  = DONE;
            set_done = 1'b1;
          end else begin
            state_d = ERR;
            set_err = 1'b1;
          end
        end
      end
      SKIP: begin
        if (!bus.program_mode)              state_d = HUNT;
        else if (consume && skip_rem == 15'd1) state_d = HUNT;
      end
      DONE:    state_d = HUNT;
      ERR:     state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // Byte window, field bit counter, header latches, skip counter and daisy-chain tap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ser_out_q <= 1'b0;
      sr8       <= '0;
      bcnt      <= '0;
      id_q      <= '0;
      skip_rem  <= '0;
    end else begin
      ser_out_q <= bus.ser_in;
      // The window starts empty on every return to HUNT.
      // Stale frame bits therefore cannot fake a sync.
      if (!bus.program_mode || (state_d == HUNT && state != HUNT))
        sr8 <= '0;
      else if (consume && (state inside {HUNT, HDR_ID, HDR_CNT, CHECK}))
        sr8 <= sr8_nx;
      if (state_d != state) bcnt <= '0;
      else if (consume)     bcnt <= bcnt + 6'd1;
      if (state == HDR_ID && byte_done) id_q <= sr8_nx;
      if (ld_skip)                            skip_rem <= {1'b0, sr8_nx, 6'b0} + 15'd8;
      else if (state == SKIP && consume)      skip_rem <= skip_rem - 15'd1;
    end
  end

  // Payload deserializer, checksum accumulator and memory write pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr64    <= '0;
      widx    <= '0;
      n_words <= '0;
      chk_acc <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (ld_payload) begin
        n_words <= sr8_nx;
        widx    <= '0;
        chk_acc <= '0;
      end
      if (state == PAYLOAD && consume) begin
        sr64 <= sr64_nx;
        if (bcnt == 6'd63) begin
          we_q    <= 1'b1;
          addr_q  <= widx[ADDR_W-1:0];
          wdata_q <= sr64_nx;
          chk_acc <= chk_acc ^ byte_xor(sr64_nx);
          widx    <= widx + 8'd1;
        end
      end
    end
  end

  // Sticky result flags. A new sync clears both flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (clr_flags) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (set_done) done_q <= 1'b1;
      if (set_err)  err_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with TILE_ID=2.
module tb_prog_loader;
  logic clk, rst;
  prog_loader_if #(.ADDR_W(7)) bus();

  prog_loader #(.TILE_ID(2), .DEPTH(128), .ADDR_W(7), .SYNC(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, gap = 0, so_bad = 0, we_dbl = 0;
  logic last_in = 1'b0, last_rst = 1'b0, prev_we = 1'b0;
  logic [6:0]  wa[$];
  logic [63:0] wd[$];
  logic [3:0][63:0] fa, fs, f4;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write log, ser_out tap and back-to-back strobe monitors
  always @(posedge clk) begin
    last_in  <= bus.ser_in;
    last_rst <= rst;
  end
  always @(negedge clk) begin
    if (rst && last_rst && bus.ser_out !== last_in) so_bad++;
    if (rst && bus.ins_we) begin
      wa.push_back(bus.ins_addr);
      wd.push_back(bus.ins_wdata);
    end
    if (bus.ins_we && prev_we) we_dbl++;
    prev_we = bus.ins_we;
  end

  task automatic send_bit(input logic b);
    while (gap > 0 && int'($urandom_range(99)) < gap) begin
      @(negedge clk);
      bus.ser_valid = 1'b0;
      bus.ser_in    = 1'($urandom_range(1));
    end
    @(negedge clk);
    bus.ser_valid = 1'b1;
    bus.ser_in    = b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = 0; i < 64; i++) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.ser_valid = 1'b0;
      bus.ser_in    = 1'($urandom_range(1));
    end
  endtask

  // Leaves the bench one cycle after the last CHK bit, which is the load_done latency.
  task automatic send_frame(input logic [7:0] id, input int n,
                            input logic [3:0][63:0] ws, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(id);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) send_word(ws[i]);
    send_byte(chk);
    idle(1);
  endtask

  task automatic check_wr(input string tag, input int n, input logic [3:0][63:0] ws);
    check({tag, "_cnt"}, 64'(wa.size()), 64'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      check($sformatf("%s_a%0d", tag, i), 64'(wa[i]), 64'(i));
      check($sformatf("%s_d%0d", tag, i), wd[i], ws[i]);
    end
  endtask

  task automatic check_flags(input string tag, input logic d, input logic e);
    check({tag, "_done"}, 64'(bus.load_done), 64'(d));
    check({tag, "_err"},  64'(bus.load_err),  64'(e));
  endtask

  initial begin
    fa = {64'h0, 64'h0, 64'h0000_0000_0000_0005, 64'h0000_0000_0020_0400};
    fs = {64'h0, 64'h1111_2222_3333_4444, 64'hFFFF_0000_FFFF_0000, 64'h0000_0000_0001_02A5};
    f4 = {64'hFFFF_0000_A5A5_A5A5, 64'h0123_4567_89AB_CDEF,
          64'hDEAD_BEEF_00C0_FFEE, 64'h1122_3344_5566_7788};
    bus.program_mode = 1'b0;
    bus.ser_in       = 1'b0;
    bus.ser_valid    = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we",    64'(bus.ins_we),    64'd0);
    check("rst_addr",  64'(bus.ins_addr),  64'd0);
    check("rst_wdata", bus.ins_wdata,      64'd0);
    check("rst_busy",  64'(bus.busy),      64'd0);
    check("rst_done",  64'(bus.load_done), 64'd0);
    check("rst_err",   64'(bus.load_err),  64'd0);
    check("rst_sout",  64'(bus.ser_out),   64'd0);
    rst = 1'b1;
    bus.program_mode = 1'b1;
    idle(2);

    // Good two-word frame, with write latency checked inline
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h02);
    check("a_busy", 64'(bus.busy), 64'd1);
    send_word(fa[0]);
    @(negedge clk);
    bus.ser_valid = 1'b0;
    check("a_we_lat", 64'(bus.ins_we), 64'd1);
    check("a_addr0",  64'(bus.ins_addr), 64'd0);
    send_word(fa[1]);
    send_byte(8'h21);
    idle(1);
    check_flags("a", 1'b1, 1'b0);
    check("a_busy_done", 64'(bus.busy), 64'd0);
    idle(2);
    check("a_busy_end", 64'(bus.busy), 64'd0);
    check_wr("a", 2, fa);

    // Same frame with a bad checksum. Both writes still land.
    wa.delete(); wd.delete();
    send_frame(8'h02, 2, fa, 8'h20);
    check_flags("b", 1'b0, 1'b1);
    idle(2);
    check_wr("b", 2, fa);

    // Foreign frame of 3 words. The payload holds A5 02 01, which must not resync.
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h03);
    for (int i = 0; i < 3; i++) send_word(fs[i]);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    idle(1);
    check("s_busy199", 64'(bus.busy), 64'd1);
    send_bit(1'b0);
    idle(1);
    check("s_busy200", 64'(bus.busy), 64'd0);
    check_flags("s", 1'b0, 1'b0);
    check("s_nowr", 64'(wa.size()), 64'd0);
    send_frame(8'h02, 2, fa, 8'h21);
    check_flags("s2", 1'b1, 1'b0);
    idle(2);
    check_wr("s2", 2, fa);

    // Out-of-range word counts
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    idle(1);
    check_flags("n0", 1'b0, 1'b1);
    idle(2);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC8);
    idle(2);
    check_flags("n200", 1'b0, 1'b1);
    check("n_nowr", 64'(wa.size()), 64'd0);
    send_frame(8'h02, 2, fa, 8'h21);
    check_flags("n_ok", 1'b1, 1'b0);
    idle(2);
    check_wr("n_ok", 2, fa);

    // program_mode dropped after 1.5 words
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h02);
    send_word(fa[0]);
    for (int i = 0; i < 32; i++) send_bit(fa[1][i]);
    @(negedge clk);
    bus.program_mode = 1'b0;
    bus.ser_valid    = 1'b0;
    @(negedge clk);
    check_flags("pm", 1'b0, 1'b1);
    idle(2);
    check_wr("pm", 1, fa);
    bus.program_mode = 1'b1;
    idle(2);
    wa.delete(); wd.delete();
    send_frame(8'h02, 2, fa, 8'h21);
    check_flags("pm_ok", 1'b1, 1'b0);
    idle(2);
    check_wr("pm_ok", 2, fa);

    // Four-word load, first without gaps and then with 30% ser_valid gaps
    for (int g = 0; g < 2; g++) begin
      gap = (g == 0) ? 0 : 30;
      wa.delete(); wd.delete();
      send_frame(8'h02, 4, f4, 8'h7B);
      gap = 0;
      check_flags($sformatf("g%0d", g), 1'b1, 1'b0);
      idle(2);
      check_wr($sformatf("g%0d", g), 4, f4);
    end

    // Reset mid-payload
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h02);
    for (int i = 0; i < 40; i++) send_bit(fa[0][i]);
    @(negedge clk);
    bus.ser_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("r_we",    64'(bus.ins_we),    64'd0);
    check("r_addr",  64'(bus.ins_addr),  64'd0);
    check("r_wdata", bus.ins_wdata,      64'd0);
    check("r_busy",  64'(bus.busy),      64'd0);
    check_flags("r", 1'b0, 1'b0);
    idle(2);
    rst = 1'b1;
    for (int i = 40; i < 64; i++) send_bit(fa[0][i]);
    send_word(fa[1]);
    send_byte(8'h21);
    idle(3);
    check("r_nowr", 64'(wa.size()), 64'd0);
    check_flags("r_end", 1'b0, 1'b0);

    check("sout_tap", 64'(so_bad), 64'd0);
    check("we_dbl",   64'(we_dbl), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
